// File: rtl/param_data_loader.sv
// Streams per-PE feature and weight vectors from a read memory into a PE array.
// Write enables and accumulate pulses are delayed to line up with the returning read data.
module param_data_loader #(
   parameter int unsigned NUM_PE    = 4,
   parameter int unsigned VEC_LEN   = 3,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned MEM_LAT   = 1,
   parameter int unsigned FEAT_BASE = 0,
   parameter int unsigned WGT_BASE  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_o,
   output logic [DATA_W-1:0] data_o,
   output logic [NUM_PE-1:0] feat_en_o,
   output logic [NUM_PE-1:0] wgt_en_o,
   output logic [7:0]        elem_idx_o,
   output logic [NUM_PE-1:0] acc_en_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned PeW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   typedef enum logic [2:0] {StIdle, StLoadF, StLoadW, StAcc, StDrain} state_e;

   typedef struct packed {
      logic [NUM_PE-1:0] feat;
      logic [NUM_PE-1:0] wgt;
      logic [7:0]        k;
      logic [NUM_PE-1:0] acc;
   } token_t;

   state_e            state_q, state_d;
   logic [PeW-1:0]    pe_q, pe_d;
   logic [7:0]        k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic [NUM_PE-1:0] pe_onehot;
   logic              issue;
   logic              last_k;
   logic              last_pe;
   token_t            issue_tok;
   token_t            tok_q;
   token_t            pipe_q [MEM_LAT];
   token_t            pipe_out;

   assign last_k   = (k_q == 8'(VEC_LEN - 1));
   assign last_pe  = (pe_q == PeW'(NUM_PE - 1));
   assign pipe_out = pipe_q[MEM_LAT-1];
   assign issue    = en_i && (state_q inside {StLoadF, StLoadW, StAcc});

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and counter logic; en_i low freezes everything while issuing
   always_comb begin
      state_d = state_q;
      pe_d    = pe_q;
      k_d     = k_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StLoadF;
               pe_d    = '0;
               k_d     = '0;
            end
         end
         StLoadF: begin
            if (en_i) begin
               if (last_k) begin
                  state_d = StLoadW;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 8'd1;
               end
            end
         end
         StLoadW: begin
            if (en_i) begin
               if (last_k) begin
                  state_d = StAcc;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 8'd1;
               end
            end
         end
         StAcc: begin
            if (en_i) begin
               if (last_pe) begin
                  state_d = StDrain;
               end else begin
                  pe_d    = pe_q + PeW'(1);
                  state_d = StLoadF;
               end
            end
         end
         StDrain: begin
            // Only one acc token for the last PE exists per job
            if (pipe_out.acc[NUM_PE-1]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Issue-side outputs: next read address/strobe and the token entering the delay line
   always_comb begin
      pe_onehot = '0;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
         pe_onehot[i] = (pe_q == PeW'(i));
      end
      issue_tok = '0;
      addr_d    = addr_q;
      rd_d      = 1'b0;
      if (issue) begin
         case (state_q)
            StLoadF: begin
               addr_d         = ADDR_W'(FEAT_BASE + 32'(pe_q) * VEC_LEN + 32'(k_q));
               rd_d           = 1'b1;
               issue_tok.feat = pe_onehot;
               issue_tok.k    = k_q;
            end
            StLoadW: begin
               addr_d        = ADDR_W'(WGT_BASE + 32'(pe_q) * VEC_LEN + 32'(k_q));
               rd_d          = 1'b1;
               issue_tok.wgt = pe_onehot;
               issue_tok.k   = k_q;
            end
            StAcc: begin
               issue_tok.acc = pe_onehot;
            end
            default: ;
         endcase
      end
      busy_o = (state_q != StIdle);
      done_o = (state_q == StDrain) && pipe_out.acc[NUM_PE-1];
   end

   // Counters, read port register and the MEM_LAT-deep token delay line
   always_ff @(posedge clk) begin
      if (rst) begin
         pe_q   <= '0;
         k_q    <= '0;
         addr_q <= '0;
         rd_q   <= 1'b0;
         tok_q  <= '0;
         for (int unsigned i = 0; i < MEM_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pe_q      <= pe_d;
         k_q       <= k_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         tok_q     <= issue_tok;
         pipe_q[0] <= tok_q;
         for (int unsigned i = 1; i < MEM_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign mem_addr_o = addr_q;
   assign mem_rd_o   = rd_q;
   assign data_o     = mem_data_i;
   assign feat_en_o  = pipe_out.feat;
   assign wgt_en_o   = pipe_out.wgt;
   assign elem_idx_o = pipe_out.k;
   assign acc_en_o   = pipe_out.acc;

endmodule

// File: tb/tb_param_data_loader.sv
// Directed bench for param_data_loader: default job, deep memory latency, en_i bubbles,
// start while busy, mid-job reset and a wide-vector configuration with address wrap.
module tb_param_data_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en, start_a, start_b, start_c;

   logic [5:0] addr_a, addr_b, addr_c;
   logic       rd_a, rd_b, rd_c;
   logic [7:0] mem_a, mem_b, mem_c, data_a, data_b, data_c;
   logic [3:0] feat_a, wgt_a, acc_a, feat_b, wgt_b, acc_b;
   logic [1:0] feat_c, wgt_c, acc_c;
   logic [7:0] idx_a, idx_b, idx_c;
   logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

   param_data_loader u_a (
      .clk(clk), .rst(rst), .start_i(start_a), .en_i(en), .mem_data_i(mem_a),
      .mem_addr_o(addr_a), .mem_rd_o(rd_a), .data_o(data_a), .feat_en_o(feat_a),
      .wgt_en_o(wgt_a), .elem_idx_o(idx_a), .acc_en_o(acc_a), .busy_o(busy_a), .done_o(done_a)
   );

   param_data_loader #(.MEM_LAT(3)) u_b (
      .clk(clk), .rst(rst), .start_i(start_b), .en_i(en), .mem_data_i(mem_b),
      .mem_addr_o(addr_b), .mem_rd_o(rd_b), .data_o(data_b), .feat_en_o(feat_b),
      .wgt_en_o(wgt_b), .elem_idx_o(idx_b), .acc_en_o(acc_b), .busy_o(busy_b), .done_o(done_b)
   );

   param_data_loader #(.NUM_PE(2), .VEC_LEN(40), .FEAT_BASE(40)) u_c (
      .clk(clk), .rst(rst), .start_i(start_c), .en_i(en), .mem_data_i(mem_c),
      .mem_addr_o(addr_c), .mem_rd_o(rd_c), .data_o(data_c), .feat_en_o(feat_c),
      .wgt_en_o(wgt_c), .elem_idx_o(idx_c), .acc_en_o(acc_c), .busy_o(busy_c), .done_o(done_c)
   );

   // Memory models: data = read address + 0x40, returned a fixed number of cycles later
   logic [7:0] mq_a [4];
   logic [7:0] mq_b [4];
   logic [7:0] mq_c [4];
   always @(posedge clk) begin
      mq_a[0] <= rd_a ? 8'h40 + 8'(addr_a) : 8'h00;
      mq_b[0] <= rd_b ? 8'h40 + 8'(addr_b) : 8'h00;
      mq_c[0] <= rd_c ? 8'h40 + 8'(addr_c) : 8'h00;
      for (int i = 1; i < 4; i++) begin
         mq_a[i] <= mq_a[i-1];
         mq_b[i] <= mq_b[i-1];
         mq_c[i] <= mq_c[i-1];
      end
   end
   assign mem_a = mq_a[0];
   assign mem_b = mq_b[2];
   assign mem_c = mq_c[0];

   // Observation mux onto one set of signals so a single job checker serves all instances
   int cur;
   logic [31:0] o_addr, o_rd, o_data, o_feat, o_wgt, o_acc, o_idx, o_busy, o_done;
   always_comb begin
      o_addr = 32'(addr_a); o_rd = 32'(rd_a); o_data = 32'(data_a); o_feat = 32'(feat_a);
      o_wgt = 32'(wgt_a); o_acc = 32'(acc_a); o_idx = 32'(idx_a);
      o_busy = 32'(busy_a); o_done = 32'(done_a);
      if (cur == 1) begin
         o_addr = 32'(addr_b); o_rd = 32'(rd_b); o_data = 32'(data_b); o_feat = 32'(feat_b);
         o_wgt = 32'(wgt_b); o_acc = 32'(acc_b); o_idx = 32'(idx_b);
         o_busy = 32'(busy_b); o_done = 32'(done_b);
      end else if (cur == 2) begin
         o_addr = 32'(addr_c); o_rd = 32'(rd_c); o_data = 32'(data_c); o_feat = 32'(feat_c);
         o_wgt = 32'(wgt_c); o_acc = 32'(acc_c); o_idx = 32'(idx_c);
         o_busy = 32'(busy_c); o_done = 32'(done_c);
      end
   end

   int total_n = 0;
   int bad_n = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total_n++;
      assert (obs === exp_v) else begin
         bad_n++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start_a = v;
      else if (sel == 1) start_b = v;
      else start_c = v;
   endtask

   // Issue slot used at edge e (edge 0 = start acceptance), or -1 for none/bubble
   function automatic int issue_slot(input int e, input int gs, input int gl);
      if (e < 1) return -1;
      if (gl > 0 && e >= gs && e < gs + gl) return -1;
      return e - 1 - ((gl > 0 && e >= gs + gl) ? gl : 0);
   endfunction

   // kind: 0 none, 1 feature read, 2 weight read, 3 accumulate
   task automatic decode(input int s, input int np, input int vl, input int fb, input int wb,
                         output int kind, output int pe, output int k, output int addr);
      int per, r;
      per = 2 * vl + 1;
      kind = 0; pe = 0; k = 0; addr = 0;
      if (s >= 0 && s < np * per) begin
         pe = s / per;
         r  = s % per;
         if (r < vl) begin
            kind = 1; k = r; addr = (fb + pe * vl + r) & 63;
         end else if (r < 2 * vl) begin
            kind = 2; k = r - vl; addr = (wb + pe * vl + k) & 63;
         end else begin
            kind = 3;
         end
      end
   endtask

   // Runs one job from start, checking every output each cycle through one cycle past done
   task automatic run_job(input int sel, input int np, input int vl, input int fb, input int wb,
                          input int lat, input int gs, input int gl, input int sp);
      int done_c, ik, ipe, ikk, iaddr, ok, ope, okk, oaddr;
      logic [31:0] oh;
      cur = sel;
      done_c = np * (2 * vl + 1) + gl + lat;
      set_start(sel, 1'b1);
      en = 1'b1;
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      for (int c = 1; c <= done_c + 1; c++) begin
         en = !(gl > 0 && c >= gs && c < gs + gl);
         set_start(sel, sp > 0 && c == sp);
         @(posedge clk);
         #1;
         decode(issue_slot(c, gs, gl), np, vl, fb, wb, ik, ipe, ikk, iaddr);
         decode(issue_slot(c - lat, gs, gl), np, vl, fb, wb, ok, ope, okk, oaddr);
         oh = 32'd1 << ope;
         chk($sformatf("u%0d c%0d mem_rd", sel, c), o_rd, 32'(ik == 1 || ik == 2));
         if (ik == 1 || ik == 2) chk($sformatf("u%0d c%0d mem_addr", sel, c), o_addr, 32'(iaddr));
         chk($sformatf("u%0d c%0d feat_en", sel, c), o_feat, ok == 1 ? oh : 32'd0);
         chk($sformatf("u%0d c%0d wgt_en", sel, c), o_wgt, ok == 2 ? oh : 32'd0);
         chk($sformatf("u%0d c%0d acc_en", sel, c), o_acc, ok == 3 ? oh : 32'd0);
         chk($sformatf("u%0d c%0d elem_idx", sel, c), o_idx, (ok == 1 || ok == 2) ? 32'(okk) : 0);
         if (ok == 1 || ok == 2) chk($sformatf("u%0d c%0d data", sel, c), o_data, 32'(oaddr + 64));
         chk($sformatf("u%0d c%0d done", sel, c), o_done, 32'(c == done_c));
         chk($sformatf("u%0d c%0d busy", sel, c), o_busy, 32'(c <= done_c));
      end
      en = 1'b1;
      set_start(sel, 1'b0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; cur = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset busy", o_busy, 0);
      chk("reset done", o_done, 0);
      chk("reset mem_rd", o_rd, 0);
      chk("reset mem_addr", o_addr, 0);
      chk("reset feat_en", o_feat, 0);
      chk("reset acc_en", o_acc, 0);

      // Default job with an ignored start pulse at edge 10, then an identical second job
      run_job(0, 4, 3, 0, 12, 1, 0, 0, 10);
      run_job(0, 4, 3, 0, 12, 1, 0, 0, 0);
      // en_i low for edges 5..7 during the PE0 weight load
      run_job(0, 4, 3, 0, 12, 1, 5, 3, 0);

      // Reset during a job: outputs clear on the next edge, no done, then a clean restart
      cur = 0;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst busy", o_busy, 0);
      chk("midrst done", o_done, 0);
      chk("midrst mem_rd", o_rd, 0);
      chk("midrst mem_addr", o_addr, 0);
      chk("midrst feat_en", o_feat, 0);
      chk("midrst wgt_en", o_wgt, 0);
      chk("midrst acc_en", o_acc, 0);
      chk("midrst elem_idx", o_idx, 0);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("postrst c%0d done", c), o_done, 0);
         chk($sformatf("postrst c%0d busy", c), o_busy, 0);
      end
      run_job(0, 4, 3, 0, 12, 1, 0, 0, 0);

      // Three-cycle memory latency
      run_job(1, 4, 3, 0, 12, 3, 0, 0, 0);
      // Long vectors with feature addresses wrapping modulo 64
      run_job(2, 2, 40, 40, 12, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/param_data_loader.md
Name: param_data_loader

Overview:
- Parametrised sequencer that streams feature and weight vectors from a single-port read memory into NUM_PE processing elements.
- After each PE's two vectors are loaded, it pulses that PE's accumulate enable.
- Control outputs are delayed by a MEM_LAT-deep pipeline so they arrive aligned with read data.
- Sits between the on-chip data memory and the PE array, under the top-level controller's start/done handshake.

Parameters:
- NUM_PE, 4, number of PEs / enable lanes (1..16)
- VEC_LEN, 3, elements per feature vector and per weight vector (1..255)
- DATA_W, 8, memory data width
- ADDR_W, 6, memory address width
- MEM_LAT, 1, memory read latency in cycles (1..4)
- FEAT_BASE, 0, base address of feature region
- WGT_BASE, 12, base address of weight region

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  start request; sampled only while busy_o=0
- en_i  in  1  issue enable; low inserts bubbles
- mem_data_i  in  DATA_W  memory read data, valid MEM_LAT cycles after issue
- mem_addr_o  out  ADDR_W  registered read address
- mem_rd_o  out  1  registered read strobe
- data_o  out  DATA_W  combinational copy of mem_data_i
- feat_en_o  out  NUM_PE  one-hot feature-buffer write enable, aligned to data_o
- wgt_en_o  out  NUM_PE  one-hot weight-buffer write enable, aligned to data_o
- elem_idx_o  out  8  element index k for the current feat/wgt write
- acc_en_o  out  NUM_PE  one-hot accumulate pulse
- busy_o  out  1  high from start acceptance until the cycle after done_o
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - All outputs go to 0; FSM goes to IDLE; counters and the delay pipeline clear.
  - A reset mid-operation aborts the transfer; no done_o is produced.
- States: IDLE, LOAD_F, LOAD_W, ACC, DRAIN.
  - IDLE: start_i=1 and busy_o=0 at edge t moves to LOAD_F with pe=0, k=0; busy_o=1 from t+1. start_i while busy is ignored.
  - LOAD_F: each issue cycle drives mem_addr_o = FEAT_BASE + pe*VEC_LEN + k, mem_rd_o=1. Increment k; at k=VEC_LEN-1 go to LOAD_W with k=0.
  - LOAD_W: same pattern with WGT_BASE; at k=VEC_LEN-1 go to ACC.
  - ACC: one cycle, no read (mem_rd_o=0). Issues an acc token for pe. If pe=NUM_PE-1 go to DRAIN, else pe++ and go to LOAD_F.
  - DRAIN: wait until the final acc token exits the pipeline, then go to IDLE.
- Issue cycles per job: NUM_PE*(2*VEC_LEN+1), i.e. 28 at defaults.
- Address arithmetic is done at full width and truncated to ADDR_W (wrap modulo 2^ADDR_W). No range error is flagged.
- en_i=0 in LOAD_F/LOAD_W/ACC:
  - Counters and FSM hold; mem_rd_o=0.
  - A bubble (all enables 0) enters the pipeline.
  - The pipeline always advances, so tokens already in flight still emerge on time.
- Delay pipeline: MEM_LAT stages carrying {feat one-hot, wgt one-hot, k, acc one-hot}.
  - A token issued at cycle t appears on feat_en_o/wgt_en_o/elem_idx_o/acc_en_o at t+MEM_LAT, the same cycle mem_data_i/data_o carries the read data.
  - At most one bit across feat_en_o|wgt_en_o|acc_en_o is high in any cycle.
  - elem_idx_o is 0 when no feat/wgt enable is active.
- done_o: asserted in the same cycle as the final acc_en_o[NUM_PE-1] pulse. busy_o drops the following cycle. A new start_i is accepted from that cycle onward.
- en_i has no effect in IDLE or DRAIN.

Test Plan:
- Defaults, en_i=1, start at cycle 0:
  - addresses 0,1,2,12,13,14,(no read),3,4,5,15,16,17,… in cycles 1..28
  - feat_en_o=0001 at cycles 2–4, wgt_en_o=0001 at cycles 5–7, acc_en_o=0001 at cycle 8
  - acc_en_o=1000 and done_o at cycle 29; busy_o=0 at cycle 30
- MEM_LAT=3, mem model returns addr+0x40:
  - every feat/wgt enable coincides with data_o = issued address+0x40, 3 cycles after issue
  - done_o at cycle 31
- en_i low for cycles 5–7 during PE0 weight load:
  - no reads in those cycles
  - bubble gaps in wgt_en_o at matching delayed cycles
  - data/enable pairing intact; done_o delayed by exactly 3 cycles (cycle 32)
- start_i pulsed at cycle 10 while busy: ignored, single done_o at cycle 29. start_i at cycle 30 launches a second identical job.
- rst asserted at cycle 15:
  - all outputs 0 at cycle 16 (next edge)
  - no done_o; busy_o=0
  - a fresh start restarts at address FEAT_BASE
- NUM_PE=2, VEC_LEN=40, FEAT_BASE=40, ADDR_W=6:
  - PE1 feature addresses wrap to 16..55 (mod 64)
  - elem_idx_o counts 0..39
  - done_o at cycle 163
